// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - funct3 codes, FSM state type and wait-counter width for npc_lsu.
package npc_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/npc_lsu_align.sv
// rtl/npc_lsu_align.sv - combinational store lane shifting, load extraction and error decode.
// NPC_LSU_MISALIGN_CHECK_EN adds halfword/word misalignment errors.
module npc_lsu_align
  import npc_lsu_pkg::*;
(
  input  logic        wen,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [15:0] sh;

  // Only the low halfword of the shifted word is ever consumed.
  assign sh = 16'(rdata >> {off, 3'b000});

  always_comb begin
    wmask     = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    err       = 1'b0;
    if (wen) begin
      case (funct3)
        F3_B: begin
          wmask    = 4'b0001 << off;
          wdata_sh = {24'h0, wdata[7:0]} << {off, 3'b000};
        end
        F3_H: begin
          wmask    = 4'b0011 << off;
          wdata_sh = {16'h0, wdata[15:0]} << {off, 3'b000};
        end
        F3_W: begin
          wmask    = 4'b1111;
          wdata_sh = wdata;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
        F3_BU:   rdata_ext = {24'h0, sh[7:0]};
        F3_H:    rdata_ext = {{16{sh[15]}}, sh};
        F3_HU:   rdata_ext = {16'h0, sh};
        F3_W:    rdata_ext = rdata;
        default: err = 1'b1;
      endcase
    end
`ifdef NPC_LSU_MISALIGN_CHECK_EN
    if ((funct3[1:0] == 2'b01) && off[0]) begin
      err = 1'b1;
    end
    if ((funct3[1:0] == 2'b10) && (off != 2'b00)) begin
      err = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/npc_lsu.sv
// rtl/npc_lsu.sv - single-outstanding load/store unit in front of MemContrl with modelled latency.
// Optional NPC_LSU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into errors.
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int unsigned LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST =
    (LATENCY > 0) ? LAT_CNT_W'(LATENCY - 1) : '0;

  lsu_state_e             state_q, state_d;
  logic                   wen_q, wen_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            data_q, data_d;
  logic [2:0]             funct3_q, funct3_d;
  logic                   err_q, err_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;

  logic        idle, access, resp;
  logic        al_wen;
  logic [1:0]  al_off;
  logic [2:0]  al_funct3;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata_sh, al_rdata_ext;
  logic        al_err;

  assign idle   = (state_q == S_IDLE);
  assign access = (state_q == S_ACCESS);
  assign resp   = (state_q == S_RESP);

  // In IDLE the aligner decodes the incoming request; afterwards it works on the captured one.
  assign al_wen    = idle ? req_wen        : wen_q;
  assign al_off    = idle ? req_addr[1:0]  : addr_q[1:0];
  assign al_funct3 = idle ? req_funct3     : funct3_q;

  npc_lsu_align u_align (
    .wen       (al_wen),
    .off       (al_off),
    .funct3    (al_funct3),
    .wdata     (wdata_q),
    .rdata     (data_q),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata_sh),
    .rdata_ext (al_rdata_ext),
    .err       (al_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d    = req_wen;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          err_d    = al_err;
          cnt_d    = '0;
          state_d  = al_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!wen_q) begin
          data_d = mem_rdata;
        end
        state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = idle && !reset;

  // Buses are quiet outside the single ACCESS cycle so the controller never sees stale writes.
  assign mem_valid = access;
  assign mem_wen   = access && wen_q;
  assign mem_raddr = access ? {addr_q[31:2], 2'b00} : '0;
  assign mem_waddr = access ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = (access && wen_q) ? al_wdata_sh : '0;
  assign mem_wmask = {4'b0000, (access && wen_q) ? al_wmask : 4'b0000};

  assign rsp_valid = resp;
  assign rsp_err   = resp && err_q;
  assign rsp_rdata = (resp && !err_q && !wen_q) ? al_rdata_ext : '0;

endmodule

// File: tb/tb_npc_lsu.sv
// tb/tb_npc_lsu.sv - randomized self-checking bench for npc_lsu against a byte-level memory model.
// Honours NPC_LSU_MISALIGN_CHECK_EN in its error model.
module tb_npc_lsu;

  localparam int unsigned LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] dut_mem [16];
  logic        sync_mem;

  always #5 clock = ~clock;

  npc_lsu #(.LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .mem_valid  (mem_valid),
    .mem_wen    (mem_wen),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Controller stand-in: combinational read, byte-masked write at the clock edge.
  assign mem_rdata = mem_valid ? dut_mem[mem_raddr[5:2]] : 32'h0;

  always @(posedge clock) begin
    if (sync_mem) begin
      for (int i = 0; i < 16; i++) dut_mem[i] <= ref_mem[i];
    end else if (mem_valid && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) dut_mem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit exp_err(input bit w, input logic [31:0] a, input logic [2:0] f3);
    bit e;
    if (w) e = (f3 > 3'd2);
    else   e = (f3 == 3'd3) || (f3 >= 3'd6);
`ifdef NPC_LSU_MISALIGN_CHECK_EN
    if (nbytes(f3) == 2 && a[0]) e = 1'b1;
    if (nbytes(f3) == 4 && a[1:0] != 2'b00) e = 1'b1;
`else
    if (a[31] === 1'bx) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] o_rdata, output logic [7:0] o_mask,
                        output logic [31:0] o_wdata);
    int n, off, lane, cyc, pulses, vcyc, mcyc;
    bit e;
    logic [3:0]  emask;
    logic [31:0] edata, eword, erd, obs_waddr, obs_raddr;
    logic        obs_wen;
    n     = nbytes(f3);
    off   = (n == 4) ? 0 : int'(a[1:0]);
    e     = exp_err(w, a, f3);
    emask = '0;
    edata = '0;
    erd   = '0;
    eword = ref_mem[a[5:2]];
    for (int k = 0; k < n; k++) begin
      lane = off + k;
      if (lane < 4) begin
        emask[lane]        = 1'b1;
        edata[8*lane +: 8] = d[8*k +: 8];
        erd[8*k +: 8]      = eword[8*lane +: 8];
      end
    end
    if (n < 4 && !f3[2] && erd[8*n-1]) erd = erd | ~((32'h1 << (8*n)) - 32'h1);
    if (e || w) erd = '0;
    if (w && !e) begin
      for (int b = 0; b < 4; b++)
        if (emask[b]) ref_mem[a[5:2]][8*b +: 8] = edata[8*b +: 8];
    end

    @(negedge clock);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_wen    = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    rsp_ready  = 1'b0;
    @(negedge clock);
    req_wen    = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    cyc = 1; pulses = 0; vcyc = -1; mcyc = 0;
    o_mask = '0; o_wdata = '0; obs_waddr = '0; obs_raddr = '0; obs_wen = 1'b0;
    while (vcyc < 0 && cyc <= 40) begin
      if (mem_valid) begin
        pulses++;
        mcyc      = cyc;
        obs_waddr = mem_waddr;
        obs_raddr = mem_raddr;
        obs_wen   = mem_wen;
        o_mask    = mem_wmask;
        o_wdata   = mem_wdata;
      end
      if (rsp_valid) vcyc = cyc;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    check("rsp_latency", vcyc, e ? 32'd1 : 32'(2 + LAT));
    check("mem_pulses", pulses, e ? 32'd0 : 32'd1);
    if (!e) begin
      check("mem_cycle", mcyc, 32'd1);
      check("mem_waddr", obs_waddr, {a[31:2], 2'b00});
      check("mem_raddr", obs_raddr, {a[31:2], 2'b00});
      check("mem_wen", {31'h0, obs_wen}, {31'h0, w});
      if (w) begin
        check("mem_wmask", {24'h0, o_mask}, {28'h0, emask});
        check("mem_wdata", o_wdata, edata);
      end
    end
    check("rsp_err", {31'h0, rsp_err}, {31'h0, e});
    check("rsp_rdata", rsp_rdata, erd);
    o_rdata = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, erd);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
      check("hold_mem", {31'h0, mem_valid}, 32'h0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    check("idle_ready", {31'h0, req_ready}, 32'h1);
    check("idle_mem", {31'h0, mem_valid}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd;
    logic [7:0]  m;
    int pulses;
    sync_mem   = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h123480FF;
    repeat (3) @(negedge clock);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    check("rst_mem_waddr", mem_waddr, 32'h0);
    check("rst_mem_wmask", {24'h0, mem_wmask}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    sync_mem = 1'b0;
    reset    = 1'b0;

    do_req(1'b0, 32'h80000001, 32'h0, 3'b000, 0, rd, m, wd);
    check("lb_const", rd, 32'hFFFFFF80);
    do_req(1'b0, 32'h80000001, 32'h0, 3'b100, 0, rd, m, wd);
    check("lbu_const", rd, 32'h00000080);
    do_req(1'b0, 32'h80000002, 32'h0, 3'b001, 0, rd, m, wd);
    check("lh_const", rd, 32'h00001234);
    do_req(1'b1, 32'h80000003, 32'h000000AB, 3'b000, 0, rd, m, wd);
    check("sb_mask_const", {24'h0, m}, 32'h08);
    check("sb_data_const", wd, 32'hAB000000);
    do_req(1'b0, 32'h80000010, 32'h0, 3'b010, 5, rd, m, wd);
    do_req(1'b0, 32'h80000004, 32'h0, 3'b011, 1, rd, m, wd);
    check("illegal_ld_rdata", rd, 32'h0);
    do_req(1'b1, 32'h80000004, 32'h5A5A5A5A, 3'b110, 0, rd, m, wd);
    do_req(1'b0, 32'h80000002, 32'h0, 3'b010, 0, rd, m, wd);
    do_req(1'b1, 32'h80000007, 32'hCAFEBEEF, 3'b001, 0, rd, m, wd);
    do_req(1'b0, 32'h80000007, 32'h0, 3'b101, 0, rd, m, wd);

    for (int t = 0; t < 150; t++) begin
      do_req(1'($urandom), 32'h80000000 | 32'($urandom_range(0, 63)), $urandom,
             3'($urandom), int'($urandom_range(0, 3)), rd, m, wd);
    end

    @(negedge clock);
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = 32'h80000010;
    req_funct3 = 3'b010;
    @(negedge clock);
    req_valid = 1'b0;
    pulses = int'(mem_valid);
    @(negedge clock);
    check("wait_no_rsp", {31'h0, rsp_valid}, 32'h0);
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("midrst_req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      pulses += int'(mem_valid);
      check("postrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("postrst_req_ready", {31'h0, req_ready}, 32'h1);
    end
    check("midrst_pulses", pulses, 32'd1);
    do_req(1'b1, 32'h80000020, 32'h13579BDF, 3'b010, 1, rd, m, wd);
    check("post_sw_mask", {24'h0, m}, 32'h0F);

    for (int i = 0; i < 16; i++) check("mem_image", dut_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
